// File: rtl/mult_cop_pkg.sv
// Shared types and defaults for the mult_cop sequential multiply coprocessor.
package mult_cop_pkg;

    typedef enum logic [1:0] {MC_IDLE, MC_RUN, MC_DONE} mc_state_t;

    localparam int MC_W_DEF = 16;

endpackage

// File: rtl/mult_cop_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand to the upper half, then shift right.
module mult_cop_step
    import mult_cop_pkg::*;
#(
    parameter int W = MC_W_DEF
) (
    input  logic [2*W-1:0] i_p,
    input  logic [W-1:0]   i_a,
    output logic [2*W-1:0] o_p
);

    logic [W:0] w_addend;
    logic [W:0] w_sum;

    // The sum keeps W+1 bits so the carry shifts into the upper half instead of being lost.
    assign w_addend = i_p[0] ? {1'b0, i_a} : '0;
    assign w_sum    = {1'b0, i_p[2*W-1:W]} + w_addend;
    assign o_p      = {w_sum, i_p[W-1:1]};

endmodule

// File: rtl/mult_cop.sv
// Sequential unsigned multiply coprocessor answering the program counter's wait handshake.
// Optional macro MULT_COP_ZERO_EN: a zero operand completes on the accept edge without entering RUN.
module mult_cop
    import mult_cop_pkg::*;
#(
    parameter int W = MC_W_DEF
) (
    input  logic           ck,
    input  logic           rb,
    input  logic           mstr,
    input  logic [W-1:0]   mopa,
    input  logic [W-1:0]   mopb,
    output logic           crdy,
    output logic           mvld,
    output logic [2*W-1:0] mprd,
    output logic           merr
);

    localparam int CW = $clog2(W + 1);

    mc_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a;
    logic [2*W-1:0]  r_p;
    logic            r_crdy;
    logic            r_mvld;
    logic            r_merr;
    logic [2*W-1:0]  w_p_next;

    mult_cop_step #(.W(W)) u_step (
        .i_p (r_p),
        .i_a (r_a),
        .o_p (w_p_next)
    );

`ifdef MULT_COP_ZERO_EN
    logic w_zero_op;
    assign w_zero_op = (mopa == '0) || (mopb == '0);
`endif

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge ck) begin
        if (rb) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_p     <= '0;
            r_crdy  <= 1'b1;
            r_mvld  <= 1'b0;
            r_merr  <= 1'b0;
        end else begin
            case (r_state)
                MC_RUN: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (mstr) begin
                        r_merr <= 1'b1;
                    end
                    if (r_cnt == CW'(1)) begin
                        r_state <= MC_DONE;
                        r_crdy  <= 1'b1;
                        r_mvld  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE otherwise holds its result indefinitely.
                    if (mstr) begin
                        r_merr <= 1'b0;
                        r_a    <= mopa;
`ifdef MULT_COP_ZERO_EN
                        if (w_zero_op) begin
                            r_state <= MC_DONE;
                            r_p     <= '0;
                            r_cnt   <= '0;
                            r_crdy  <= 1'b1;
                            r_mvld  <= 1'b1;
                        end else begin
                            r_state <= MC_RUN;
                            r_p     <= {{W{1'b0}}, mopb};
                            r_cnt   <= CW'(W);
                            r_crdy  <= 1'b0;
                            r_mvld  <= 1'b0;
                        end
`else
                        r_state <= MC_RUN;
                        r_p     <= {{W{1'b0}}, mopb};
                        r_cnt   <= CW'(W);
                        r_crdy  <= 1'b0;
                        r_mvld  <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign crdy = r_crdy;
    assign mvld = r_mvld;
    assign mprd = r_p;
    assign merr = r_merr;

endmodule

// File: doc/mult_cop.md
Name: mult_cop

Overview:
- Sequential unsigned multiply coprocessor; the responder on the program counter's wait handshake.
- Instruction decoder pulses a start with two operands.
- Block runs a radix-2 shift-add multiply and drives crdy, which the program counter's wait opcode polls before advancing.
- crdy is high whenever no multiply is pending, so a wait with nothing outstanding falls straight through.

Parameters:
- W, 16, operand width in bits; product is 2W bits; W >= 2.
- CW, $clog2(W+1), step-counter width, derived; not overridden.

Ports:
- ck  input  1  clock, all state on rising edge.
- rb  input  1  reset, synchronous, active-high; reset wins over every other input on the same edge.
- mstr  input  1  start strobe from the instruction decoder, sampled each rising edge.
- mopa  input  W  multiplicand, captured on the accept edge.
- mopb  input  W  multiplier, captured on the accept edge.
- crdy  output  1  coprocessor ready; low while a multiply is in progress; drives the program counter's wait input.
- mvld  output  1  mprd holds the result of the most recent completed multiply.
- mprd  output  2W  product register.
- merr  output  1  sticky flag: mstr seen while busy.

Behaviour:
- Reset (rb=1 at edge):
  - state=IDLE, crdy=1, mvld=0, mprd=0, merr=0, step counter=0.
  - Reset mid-operation abandons the multiply with no partial result visible.
- States: IDLE, RUN, DONE. crdy=1 in IDLE/DONE, 0 in RUN. mvld=1 only in DONE.
- Accept: mstr=1 at an edge while in IDLE or DONE. On that same edge:
  - P[2W-1:W]=0, P[W-1:0]=mopb, Areg=mopa, counter=W.
  - merr=0, mvld=0, crdy=0, state=RUN.
  - crdy falls on the accept edge itself, so a wait issued in the next instruction slot stalls.
- RUN step, every edge:
  - sum = P[2W-1:W] + (P[0] ? Areg : 0), W+1 bits, no overflow lost.
  - P = {sum, P[W-1:1]}; counter decrements.
  - On the edge where counter goes 1->0: state=DONE, crdy=1, mvld=1.
  - mprd = P during RUN (intermediate values visible but qualified by mvld=0); final mprd = Areg*mopb exactly, 2W bits.
- Latency: crdy is low for exactly W cycles. Accept at edge t gives crdy=1 and a valid mprd after edge t+W.
- mstr=1 during RUN: ignored; operation continues unchanged; merr set to 1 and held until reset or next accepted start.
- mstr held high continuously: re-accepted on the first edge in DONE, so a new multiply starts immediately. crdy is high for that edge-interval only, then falls again.
- mopa/mopb changes after the accept edge have no effect.
- DONE holds mprd/crdy/mvld indefinitely until the next accept or reset.

Optional Feature:
- Macro: MULT_COP_ZERO_EN.
- Defined:
  - On accept, if mopa==0 or mopb==0, skip RUN: state=DONE directly on the accept edge, mprd=0, mvld=1, crdy stays 1.
  - The next wait passes with zero stall.
  - merr still cleared.
- Undefined:
  - Zero operands take the full W-cycle RUN path; result 0.
  - No comparator logic is present.

Decomposition:
- Package mult_cop_pkg holds:
  - typedef enum logic [1:0] {MC_IDLE, MC_RUN, MC_DONE} mc_state_t;
  - localparam MC_W_DEF = 16.
- Sub-module mult_cop_step: purely combinational single shift-add step.
  - Inputs: P (2W), Areg (W). Output: next P.
  - Instantiated once in mult_cop.
- The FSM, counter and flags stay in mult_cop.

Test Plan:
1. Reset, no start -> crdy=1, mvld=0, mprd=0, merr=0. Assert rb during a RUN -> next cycle crdy=1, mvld=0, mprd=0.
2. Basic multiply: mopa=3, mopb=5, mstr 1 cycle at edge t -> crdy=0 for edges t..t+15; after edge t+16 crdy=1, mvld=1, mprd=32'h0000000F.
3. Corner operands (W=16): FFFF*FFFF -> mprd=32'hFFFE0001. 8000*0002 -> 32'h00010000. 0001*ABCD -> 32'h0000ABCD.
4. Start while busy: start 7*9, pulse mstr again with 2*2 at RUN cycle 5 -> result 32'h0000003F on schedule, merr=1. Next accepted start clears merr.
5. Back-to-back: mstr held high with 2*3 then 4*5 switched on the DONE edge -> first mprd=6 with crdy high for one cycle, second mprd=20 after W more cycles.
6. Zero operand, mopa=0, mopb=1234: with MULT_COP_ZERO_EN, crdy never drops and mprd=0, mvld=1 after the accept edge. Without the macro, crdy is low 16 cycles, then mprd=0.
